// File: rtl/qpipe_pkg.sv
// Shared types and constants for the QueuManager issue path.
package qpipe_pkg;

    localparam int unsigned OP_W      = 10;
    localparam int unsigned INSTR_W   = 8;
    localparam logic [7:0]  NOP_INSTR = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Width of a requester index; never below one bit.
    function automatic int unsigned src_w(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/qm_issue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above the pointer, with wrap.
module rr_arbiter
    import qpipe_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned SRC_W = src_w(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [SRC_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [SRC_W-1:0] idx_o
);

    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // One conditional subtract is enough: ptr and i are both below NREQ.
            sum = {1'b0, ptr_i} + (SRC_W+1)'(i);
            if (sum >= (SRC_W+1)'(NREQ)) begin
                sum = sum - (SRC_W+1)'(NREQ);
            end
            cand = sum[SRC_W-1:0];
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (found) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/qm_issue_scheduler.sv
// Shares the QueuManager load port between NREQ requesters: round-robin grant,
// relative-to-absolute delay conversion, valid/ready issue and a post-issue gap.
module qm_issue_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned OP_W    = qpipe_pkg::OP_W,
    parameter int unsigned INSTR_W = qpipe_pkg::INSTR_W,
    parameter int unsigned GAP     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*INSTR_W-1:0] req_instr,
    input  logic [NREQ*OP_W-1:0]    req_delay,
    output logic                    qm_valid,
    input  logic                    qm_ready,
    output logic [OP_W-1:0]         qm_op,
    output logic [INSTR_W-1:0]      qm_instr,
    output logic [2:0]              qm_src,
    output logic [OP_W-1:0]         now,
    output logic                    busy
);

    import qpipe_pkg::*;

    localparam int unsigned SRC_W    = src_w(NREQ);
    localparam logic        HAS_GAP  = (GAP != 0);
    localparam logic [3:0]  GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    state_e             state_q, state_d;
    logic [3:0]         gap_q, gap_d;
    logic [OP_W-1:0]    now_q;
    logic [OP_W-1:0]    op_q, op_d;
    logic [INSTR_W-1:0] instr_q;
    logic [SRC_W-1:0]   src_q;
    logic [SRC_W-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0]    gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic [INSTR_W-1:0] gnt_instr;
    logic [OP_W-1:0]    gnt_delay;
    logic               accept;
    logic               is_nop;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign gnt_instr = req_instr[32'(gnt_idx)*INSTR_W +: INSTR_W];
    assign gnt_delay = req_delay[32'(gnt_idx)*OP_W +: OP_W];
    assign accept    = (state_q == ST_IDLE) && (|gnt);
    assign is_nop    = (gnt_instr == INSTR_W'(NOP_INSTR));
    assign op_d      = now_q + gnt_delay;
    assign ptr_d     = !accept ? ptr_q :
                       (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : gnt_idx + SRC_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic; a NOP grant is consumed without leaving IDLE
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !is_nop) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (qm_ready) begin
                    if (HAS_GAP) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; the grant is masked while reset is held so nothing looks accepted
    always_comb begin
        req_ready = '0;
        qm_valid  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE:  req_ready = rst_n ? gnt : '0;
            ST_ISSUE: begin
                qm_valid = 1'b1;
                busy     = 1'b1;
            end
            ST_GAP:   busy = 1'b1;
            default:  ;
        endcase
    end

    // Timeline counter, rr pointer and the held issue slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q   <= '0;
            ptr_q   <= '0;
            op_q    <= '0;
            instr_q <= '0;
            src_q   <= '0;
        end else begin
            now_q <= now_q + OP_W'(1);
            ptr_q <= ptr_d;
            if (accept && !is_nop) begin
                op_q    <= op_d;
                instr_q <= gnt_instr;
                src_q   <= gnt_idx;
            end
        end
    end

    assign now      = now_q;
    assign qm_op    = op_q;
    assign qm_instr = instr_q;
    assign qm_src   = 3'(src_q);

endmodule

// File: tb/tb_qm_issue_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// time-based behavioural model of the issue scheduler.
module tb_qm_issue_scheduler;

    localparam int NREQ    = 4;
    localparam int OP_W    = 10;
    localparam int INSTR_W = 8;
    localparam int GAP     = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*INSTR_W-1:0] req_instr;
    logic [NREQ*OP_W-1:0]    req_delay;
    logic                    qm_valid;
    logic                    qm_ready;
    logic [OP_W-1:0]         qm_op;
    logic [INSTR_W-1:0]      qm_instr;
    logic [2:0]              qm_src;
    logic [OP_W-1:0]         now;
    logic                    busy;

    always #5 clk = ~clk;

    qm_issue_scheduler #(
        .NREQ(NREQ), .OP_W(OP_W), .INSTR_W(INSTR_W), .GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_delay(req_delay),
        .qm_valid(qm_valid), .qm_ready(qm_ready),
        .qm_op(qm_op), .qm_instr(qm_instr), .qm_src(qm_src),
        .now(now), .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: a pending slot plus the absolute cycle from which grants are allowed again
    int m_now, m_cycle, m_free_at, m_ptr;
    bit m_pending;
    int m_op, m_instr, m_src;
    int g_idx[$];
    int g_cyc[$];
    int hs_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, m_cycle);
    endtask

    task automatic model_reset();
        m_now = 0; m_cycle = 0; m_free_at = 0; m_ptr = 0; m_pending = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [7:0] ins, input logic [9:0] dly);
        req_instr[i*INSTR_W +: INSTR_W] = ins;
        req_delay[i*OP_W +: OP_W] = dly;
    endtask

    // Compare this cycle's outputs, then advance the model across the coming edge
    task automatic model_cycle();
        logic [NREQ-1:0] exp_rdy;
        logic [7:0] ins;
        int gi;
        bit blocked;
        exp_rdy = '0;
        gi = -1;
        blocked = m_pending || (m_cycle < m_free_at);
        if (!blocked) begin
            for (int o = 0; o < NREQ; o++) begin
                int j;
                j = (m_ptr + o) % NREQ;
                if (gi < 0 && req_valid[j]) gi = j;
            end
        end
        if (gi >= 0) exp_rdy[gi] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        chk("qm_valid", 32'(qm_valid), 32'(m_pending));
        chk("busy", 32'(busy), 32'(blocked));
        chk("now", 32'(now), 32'(m_now));
        if (m_pending) begin
            chk("qm_op", 32'(qm_op), 32'(m_op));
            chk("qm_instr", 32'(qm_instr), 32'(m_instr));
            chk("qm_src", 32'(qm_src), 32'(m_src));
        end
        if (m_pending && qm_ready) begin
            m_pending = 1'b0;
            m_free_at = m_cycle + 1 + GAP;
            hs_cyc = m_cycle;
        end else if (gi >= 0) begin
            g_idx.push_back(gi);
            g_cyc.push_back(m_cycle);
            m_ptr = (gi + 1) % NREQ;
            ins = req_instr[gi*INSTR_W +: INSTR_W];
            if (ins != 8'h00) begin
                m_pending = 1'b1;
                m_op = (m_now + int'(req_delay[gi*OP_W +: OP_W])) % 1024;
                m_instr = int'(ins);
                m_src = gi;
            end
        end
        m_now = (m_now + 1) % 1024;
        m_cycle++;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free();
        for (int k = 0; k < 30 && (m_pending || m_cycle < m_free_at); k++) step();
    endtask

    initial begin
        int n, base;
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};
        req_valid = '1; req_instr = '0; req_delay = '0; qm_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_now", 32'(now), 32'd0);
        chk("rst_qm_valid", 32'(qm_valid), 32'd0);
        chk("rst_qm_op", 32'(qm_op), 32'd0);
        chk("rst_qm_instr", 32'(qm_instr), 32'd0);
        chk("rst_qm_src", 32'(qm_src), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;
        model_reset();

        // Single request accepted at now=0x010
        for (int k = 0; k < 40 && m_now != 16; k++) step();
        set_req(0, 8'hFF, 10'h005);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        set_req(1, 8'h77, 10'h100);
        req_valid = 4'b0010;
        chk("lit_valid", 32'(qm_valid), 32'd1);
        chk("lit_op", 32'(qm_op), 32'h015);
        chk("lit_instr", 32'(qm_instr), 32'hFF);
        chk("lit_src", 32'(qm_src), 32'd0);

        // Backpressure: slot must hold and nobody else gets granted
        for (int k = 0; k < 6; k++) begin
            step();
            chk("bp_valid", 32'(qm_valid), 32'd1);
            chk("bp_op", 32'(qm_op), 32'h015);
            chk("bp_instr", 32'(qm_instr), 32'hFF);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        qm_ready = 1'b1;
        step();
        n = g_idx.size();
        for (int k = 0; k < 10 && g_idx.size() == n; k++) step();
        req_valid = '0;
        chk("bp_granted", 32'(g_idx.size()), 32'(n + 1));
        chk("bp_gap_len", 32'(g_cyc[$] - hs_cyc), 32'(1 + GAP));
        chk("bp_next_src", 32'(g_idx[$]), 32'd1);
        wait_free();

        // NOP from req2 consumed, req3 granted on the following cycle
        set_req(2, 8'h00, 10'h011);
        set_req(3, 8'h3C, 10'h020);
        req_valid = 4'b1100;
        step();
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        qm_ready = 1'b0;
        chk("nop_first", 32'(g_idx[$-1]), 32'd2);
        chk("nop_second", 32'(g_idx[$]), 32'd3);
        chk("nop_spacing", 32'(g_cyc[$] - g_cyc[$-1]), 32'd1);
        chk("nop_valid", 32'(qm_valid), 32'd1);
        chk("nop_instr", 32'(qm_instr), 32'h3C);
        chk("nop_src", 32'(qm_src), 32'd3);
        qm_ready = 1'b1;
        wait_free();

        // Timeline wrap in the delay sum
        for (int k = 0; k < 1100 && m_now != 32'h3FE; k++) step();
        set_req(1, 8'h5A, 10'h003);
        req_valid = 4'b0010;
        qm_ready = 1'b0;
        step();
        req_valid = '0;
        chk("wrap_valid", 32'(qm_valid), 32'd1);
        chk("wrap_op", 32'(qm_op), 32'h001);
        qm_ready = 1'b1;
        wait_free();

        // Asynchronous reset while a slot is held
        set_req(0, 8'h11, 10'h007);
        req_valid = 4'b0001;
        qm_ready = 1'b0;
        step();
        req_valid = '0;
        chk("pre_rst_valid", 32'(qm_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(qm_valid), 32'd0);
        chk("arst_now", 32'(now), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h40 + i), 10'(i * 3));
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_valid", 32'(qm_valid), 32'd0);
        rst_n = 1'b1;
        model_reset();
        qm_ready = 1'b1;
        #1;
        chk("rr_first", 32'(req_ready), 32'b0001);

        // Round-robin with everyone requesting
        base = g_idx.size();
        for (int k = 0; k < 40 && g_idx.size() < base + 5; k++) step();
        req_valid = '0;
        chk("rr_count", 32'(g_idx.size() >= base + 5), 32'd1);
        if (g_idx.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("rr_order", 32'(g_idx[base+i]), 32'(exp_seq[i]));
                chk("rr_cycle", 32'(g_cyc[base+i]), 32'(i * (2 + GAP)));
            end
        end
        wait_free();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++)
                set_req(i, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 10'($urandom));
            qm_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
